// File: rtl/versatile_fifo_pkg.sv
// ============================================================================
// Module : versatile_fifo_pkg
// Brief  : Shared constants and pointer helpers for the single-clock FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package versatile_fifo_pkg;

  localparam int OBUF_DEPTH = 2;

  typedef logic [1:0] obuf_cnt_t;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [31:0] ptr_diff(input logic [31:0] wr_ptr,
                                           input logic [31:0] rd_ptr,
                                           input int          addr_width);
    logic [31:0] mask;
    mask = (32'd1 << (addr_width + 1)) - 32'd1;
    return (wr_ptr - rd_ptr) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/versatile_fifo_obuf.sv
// ============================================================================
// Module : versatile_fifo_obuf
// Brief  : Two-entry first-word-fall-through output buffer with push/pop.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module versatile_fifo_obuf
  import versatile_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output obuf_cnt_t             count
);

  logic [DATA_WIDTH-1:0] r_entry0;
  logic [DATA_WIDTH-1:0] r_entry1;
  obuf_cnt_t             r_count;
  logic                  w_pop;

  assign w_pop      = pop && (r_count != 2'd0);
  assign head_data  = r_entry0;
  assign head_valid = (r_count != 2'd0);
  assign count      = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_count  <= 2'd0;
    end else if (clear) begin
      r_count  <= 2'd0;
    end else begin
      case ({push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_entry0 <= push_data;
          else                 r_entry1 <= push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_entry0 <= r_entry1;
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          // Pop and load together: count is unchanged, new word goes to the tail.
          if (r_count == 2'd1) begin
            r_entry0 <= push_data;
          end else begin
            r_entry0 <= r_entry1;
            r_entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/versatile_fifo_sc_ctrl.sv
// ============================================================================
// Module : versatile_fifo_sc_ctrl
// Brief  : Single-clock FIFO controller driving an external simple dual-port
//          RAM, with a 2-entry FWFT output buffer. Optional synchronous flush
//          port enabled by macro VERSATILE_FIFO_FLUSH_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module versatile_fifo_sc_ctrl
  import versatile_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic [DATA_WIDTH-1:0] ram_d_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
`ifdef VERSATILE_FIFO_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int c_ptr_w = ptr_w(ADDR_WIDTH);
  localparam logic [c_ptr_w-1:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic               r_inflight;
  logic [c_ptr_w-1:0] w_ram_cnt;
  logic               w_wr_fire;
  logic               w_pop;
  logic               w_issue;
  logic               w_flush;
  obuf_cnt_t          w_buf_cnt;

`ifdef VERSATILE_FIFO_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_ram_cnt = c_ptr_w'(ptr_diff(32'(r_wr_ptr), 32'(r_rd_ptr), ADDR_WIDTH));

  assign wr_ready  = (w_ram_cnt != c_depth);
  assign w_wr_fire = wr_valid && wr_ready;
  assign ram_we_a  = w_wr_fire && !w_flush;
  assign ram_adr_a = r_wr_ptr[ADDR_WIDTH-1:0];
  assign ram_d_a   = wr_data;
  assign ram_adr_b = r_rd_ptr[ADDR_WIDTH-1:0];

  // Only fetch when the buffer will still have room once the in-flight word lands.
  assign w_pop   = rd_valid && rd_ready;
  assign w_issue = (w_ram_cnt != '0) &&
                   ((32'(w_buf_cnt) + 32'(r_inflight)) < (32'(OBUF_DEPTH) + 32'(w_pop)));

  assign fill_level = w_ram_cnt + c_ptr_w'(r_inflight) + c_ptr_w'(w_buf_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_inflight <= w_issue;
    end
  end

  versatile_fifo_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_flush),
    .push       (r_inflight),
    .push_data  (ram_q_b),
    .pop        (w_pop),
    .head_data  (rd_data),
    .head_valid (rd_valid),
    .count      (w_buf_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_versatile_fifo_sc_ctrl.sv
// ============================================================================
// Module : tb_versatile_fifo_sc_ctrl
// Brief  : Scoreboard bench for versatile_fifo_sc_ctrl with a behavioural RAM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_versatile_fifo_sc_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int CAP   = DEPTH + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [AW:0]   fill_level;
  logic [DW-1:0] ram_d_a;
  logic [AW-1:0] ram_adr_a;
  logic          ram_we_a;
  logic [AW-1:0] ram_adr_b;
  logic [DW-1:0] ram_q_b = '0;
`ifdef VERSATILE_FIFO_FLUSH_EN
  logic          flush = 1'b0;
`endif

  logic [DW-1:0] mem [DEPTH];

  int            n_tests = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_q [$];
  int            model_held = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  versatile_fifo_sc_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .fill_level (fill_level),
    .ram_d_a    (ram_d_a),
    .ram_adr_a  (ram_adr_a),
    .ram_we_a   (ram_we_a),
    .ram_adr_b  (ram_adr_b),
    .ram_q_b    (ram_q_b)
`ifdef VERSATILE_FIFO_FLUSH_EN
    ,
    .flush      (flush)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
    ram_q_b <= mem[ram_adr_b];
  end

  function automatic bit flush_now();
`ifdef VERSATILE_FIFO_FLUSH_EN
    return flush;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Inputs change just after the rising edge; accepted writes join the scoreboard.
  task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic rr);
    @(posedge clk);
    #1;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
`ifdef VERSATILE_FIFO_FLUSH_EN
    flush    = 1'b0;
`endif
    #1;
    if (wv && wr_ready && !flush_now()) exp_q.push_back(wd);
  endtask

  task automatic drain(input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      if (!rd_valid && fill_level == '0) break;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_fill_zero", int'(fill_level), 0);
  endtask

  // Monitor: model occupancy, ordering, write gating and hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_held = 0;
      prev_hold  = 1'b0;
    end else begin
      check("fill_level", int'(fill_level), model_held);
      if (model_held == 0) check("rd_valid_when_empty", int'(rd_valid), 0);
      if (model_held < DEPTH) check("wr_ready_with_room", int'(wr_ready), 1);
      if (model_held >= CAP) check("wr_ready_when_full", int'(wr_ready), 0);
      check("ram_we_a", int'(ram_we_a), int'(wr_valid && wr_ready && !flush_now()));
      if (prev_hold) begin
        check("rd_valid_held", int'(rd_valid), 1);
        check("rd_data_stable", int'(rd_data), int'(prev_data));
      end
      if (flush_now()) begin
        model_held = 0;
        exp_q.delete();
        prev_hold  = 1'b0;
      end else begin
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) check("read_without_write", 1, 0);
          else check("rd_data_order", int'(rd_data), int'(exp_q.pop_front()));
          model_held--;
        end
        if (wr_valid && wr_ready) model_held++;
        prev_hold = rd_valid && !rd_ready;
        prev_data = rd_data;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads;
    int bubbles;
    bit started;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_rd_data", int'(rd_data), 0);
    check("reset_wr_ready", int'(wr_ready), 1);
    check("reset_fill", int'(fill_level), 0);
    check("reset_we", int'(ram_we_a), 0);

    // Single-word latency and hold stability.
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("lat_after_edge1", int'(rd_valid), 0);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("lat_after_edge2", int'(rd_valid), 0);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("lat_after_edge3", int'(rd_valid), 1);
    check("lat_data", int'(rd_data), 'hA5);
    check("lat_fill", int'(fill_level), 1);
    repeat (5) begin
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      check("hold_data", int'(rd_data), 'hA5);
    end
    drain(10);

    // Fill to capacity with the reader stalled.
    for (int i = 0; i < CAP + 2; i++) drive(1'b1, 8'(i), 1'b0);
    repeat (4) drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("full_fill", int'(fill_level), CAP);
    check("full_wr_ready", int'(wr_ready), 0);
    check("full_accepted", exp_q.size(), CAP);
    drain(40);

    // Streaming: one word per cycle with no bubbles once data starts.
    reads = 0; bubbles = 0; started = 1'b0;
    for (int i = 0; i < 110; i++) begin
      if (i < 100) drive(1'b1, 8'(i + 7), 1'b1);
      else         drive(1'b0, '0, 1'b1);
      if (i < 100) check("stream_wr_ready", int'(wr_ready), 1);
      @(negedge clk);
      if (rd_valid) begin started = 1'b1; reads++; end
      else if (started && reads < 100) bubbles++;
    end
    check("stream_reads", reads, 100);
    check("stream_bubbles", bubbles, 0);
    drain(10);

    // Random traffic.
    for (int i = 0; i < 10000; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    drain(60);

    // Asynchronous reset with words stored.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0);
    repeat (3) drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("prereset_fill", int'(fill_level), 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rd_valid", int'(rd_valid), 0);
    check("async_rd_data", int'(rd_data), 0);
    check("async_fill", int'(fill_level), 0);
    check("async_wr_ready", int'(wr_ready), 1);
    check("async_we", int'(ram_we_a), 0);
    #3 rst_n = 1'b1;
    drive(1'b1, 8'h5A, 1'b0);
    drive(1'b0, '0, 1'b0);
    drain(10);

`ifdef VERSATILE_FIFO_FLUSH_EN
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hD0 + i), 1'b0);
    repeat (3) drive(1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    wr_valid = 1'b1; wr_data = 8'h77; rd_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_we", int'(ram_we_a), 0);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("flush_fill", int'(fill_level), 0);
    check("flush_rd_valid", int'(rd_valid), 0);
    drive(1'b1, 8'h33, 1'b0);
    drive(1'b0, '0, 1'b0);
    drain(10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/versatile_fifo_sc_ctrl.md
Name: versatile_fifo_sc_ctrl

Overview:
- Single-clock FIFO controller that sequences the simple dual-port RAM used in the FIFO library.
- RAM port A (d_a/adr_a/we_a) is used for writes only; port B (adr_b/q_b) is used for reads only.
- The RAM has no read enable: q_b is registered from adr_b on every clock.
- Presents valid/ready on both sides and first-word-fall-through read data through a 2-entry output buffer, sustaining 1 word/cycle.

Parameters:
DATA_WIDTH, 8, word width; must match the RAM.
ADDR_WIDTH, 9, RAM address width; RAM depth = 2**ADDR_WIDTH; legal values >= 2.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous reset, active low.
wr_data  in  DATA_WIDTH  write word.
wr_valid  in  1  write request.
wr_ready  out  1  controller can accept a write.
rd_data  out  DATA_WIDTH  head word; valid when rd_valid=1.
rd_valid  out  1  head word present.
rd_ready  in  1  consumer takes the head word.
fill_level  out  ADDR_WIDTH+1  total words held: RAM + in-flight + buffer.
ram_d_a  out  DATA_WIDTH  to RAM d_a.
ram_adr_a  out  ADDR_WIDTH  to RAM adr_a.
ram_we_a  out  1  to RAM we_a.
ram_adr_b  out  ADDR_WIDTH  to RAM adr_b.
ram_q_b  in  DATA_WIDTH  from RAM q_b; valid 1 cycle after adr_b.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - wr_ptr = rd_ptr = 0 (ADDR_WIDTH+1 bits each, MSB is the wrap bit); inflight = 0; buffer empty.
  - Outputs: rd_valid=0, rd_data=0, fill_level=0, ram_we_a=0, wr_ready=1.
- ram_cnt = wr_ptr - rd_ptr, registered-pointer difference, range 0..2**ADDR_WIDTH.
- Write side:
  - wr_ready = (ram_cnt != 2**ADDR_WIDTH).
  - On wr_valid & wr_ready: ram_we_a=1, ram_adr_a = wr_ptr[ADDR_WIDTH-1:0], ram_d_a = wr_data (all combinational, same cycle); wr_ptr increments at the edge.
  - Pointer wrap is modulo 2**(ADDR_WIDTH+1).
- Read issue:
  - ram_adr_b = rd_ptr[ADDR_WIDTH-1:0] at all times.
  - issue = (ram_cnt != 0) & (buf_cnt + inflight - pop < 2), where pop = rd_valid & rd_ready.
  - On issue: rd_ptr increments and inflight is set to 1 for the next cycle; otherwise inflight is cleared.
- Buffer load: when inflight=1, ram_q_b is written into the buffer at that edge, in FIFO order behind any held word.
- Buffer output:
  - rd_data/rd_valid come from buffer entry 0.
  - On pop, entry 1 shifts to entry 0.
  - Simultaneous pop and load are legal with no bubble.
- Latency: a write accepted at edge n gives rd_valid=1 after edge n+2 when the FIFO was empty.
- Throughput: continuous writes with rd_ready=1 give one word per cycle.
- Hazard:
  - A read issue to the address written in the same cycle cannot occur: issue requires ram_cnt>0 from registered pointers, and a full RAM blocks writes.
  - The RAM's no_rw_check style is therefore safe.
- Simultaneous write and read issue: both pointers move; ram_cnt is unchanged.
- fill_level = ram_cnt + inflight + buf_cnt; maximum 2**ADDR_WIDTH + 2.
  - wr_ready depends only on ram_cnt, so up to 2**ADDR_WIDTH+2 words can be held.
- Protocol rules:
  - rd_data is stable while rd_valid=1 and rd_ready=0.
  - wr_ready does not depend on wr_valid.
- Reset mid-operation: all state clears immediately and outputs return to reset values; RAM contents are don't-care.

Optional Feature:
VERSATILE_FIFO_FLUSH_EN
- With the macro: adds input flush (1 bit, synchronous).
  - flush=1 at an edge clears the pointers, inflight and buffer.
  - The next cycle shows rd_valid=0, fill_level=0.
  - A write accepted in the flush cycle is discarded; ram_we_a is forced to 0 while flush=1.
  - flush has priority over all other events.
- Without the macro: the port is absent and the behaviour above is unchanged.

Decomposition:
- Package versatile_fifo_pkg:
  - PTR_W = ADDR_WIDTH+1 helper.
  - Pointer-difference function.
  - Output-buffer depth constant OBUF_DEPTH = 2.
- One sub-module: versatile_fifo_obuf, the 2-entry output buffer with push/pop, count and FIFO ordering.

Test Plan:
- Reset then idle: rd_valid=0, wr_ready=1, fill_level=0, ram_we_a=0.
- Write 0xA5 at edge 1 with rd_ready=0: rd_valid=1 after edge 3, rd_data=0xA5, fill_level=1; hold rd_ready=0 for 5 cycles, data stable.
- ADDR_WIDTH=2, rd_ready=0, write 0..7: 6 accepted (4 RAM + 2 buffer), then wr_ready=0, fill_level=6; read all 6 in order 0..5.
- Streaming: 100 writes with rd_ready=1 every cycle: 100 reads in order, no bubbles after the first word, wr_ready stays 1.
- Random wr_valid/rd_ready at 50%, 10k cycles, ADDR_WIDTH=3: scoreboard matches, fill_level always equals writes minus reads, no write while ram_cnt=8.
- rst_n pulsed low with 5 words stored: outputs return to reset values asynchronously. With VERSATILE_FIFO_FLUSH_EN, flush with 5 words stored gives fill_level=0 the next cycle, and the word written in the flush cycle is not read back.
